// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : hazard_scoreboard
// Brief   : Decode-side hazard controller with a shadow E/M/W pipeline,
//           stall/flush/forward generation and saturating event counters.
// Rev     : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           Rs1D,
    input  logic [4:0]           Rs2D,
    input  logic [4:0]           RdD,
    input  logic                 RegWriteD,
    input  logic [1:0]           ResultSrcD,
    input  logic                 PCSrcE,
    input  logic                 MemStallM,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    localparam logic [1:0]           c_fwd_none = 2'b00;
    localparam logic [1:0]           c_fwd_w    = 2'b01;
    localparam logic [1:0]           c_fwd_m    = 2'b10;
    localparam logic [1:0]           c_src_load = 2'b01;
    localparam logic [CNT_WIDTH-1:0] c_cnt_one  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] c_cnt_max  = {CNT_WIDTH{1'b1}};

    // Shadow pipeline slots
    logic       r_e_valid, r_e_regwrite, r_e_load;
    logic [4:0] r_e_rd, r_e_rs1, r_e_rs2;
    logic       r_m_valid, r_m_regwrite, r_m_load;
    logic [4:0] r_m_rd;
    logic       r_w_valid, r_w_regwrite, r_w_load;
    logic [4:0] r_w_rd;

    logic [CNT_WIDTH-1:0] r_stall_cnt, r_flush_cnt;

    logic w_lw_stall;

    // x0 is hardwired zero, so a slot targeting it never produces a hazard.
    function automatic logic slot_match(input logic v, input logic rw,
                                        input logic [4:0] rd, input logic [4:0] r);
        return v & rw & (rd != 5'd0) & (rd == r);
    endfunction

    assign w_lw_stall = r_e_load &
                        (slot_match(r_e_valid, r_e_regwrite, r_e_rd, Rs1D) |
                         slot_match(r_e_valid, r_e_regwrite, r_e_rd, Rs2D));

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (MemStallM) begin
            StallF = 1'b1;
            StallD = 1'b1;
        end else begin
            StallF = w_lw_stall;
            StallD = w_lw_stall;
            FlushD = PCSrcE;
            FlushE = w_lw_stall | PCSrcE;
        end
    end

    always_comb begin
        ForwardAE = c_fwd_none;
        ForwardBE = c_fwd_none;
        if (r_e_valid) begin
            if (slot_match(r_m_valid, r_m_regwrite, r_m_rd, r_e_rs1))
                ForwardAE = c_fwd_m;
            else if (slot_match(r_w_valid, r_w_regwrite, r_w_rd, r_e_rs1))
                ForwardAE = c_fwd_w;

            if (slot_match(r_m_valid, r_m_regwrite, r_m_rd, r_e_rs2))
                ForwardBE = c_fwd_m;
            else if (slot_match(r_w_valid, r_w_regwrite, r_w_rd, r_e_rs2))
                ForwardBE = c_fwd_w;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_e_valid    <= 1'b0;
            r_e_regwrite <= 1'b0;
            r_e_load     <= 1'b0;
            r_e_rd       <= 5'd0;
            r_e_rs1      <= 5'd0;
            r_e_rs2      <= 5'd0;
            r_m_valid    <= 1'b0;
            r_m_regwrite <= 1'b0;
            r_m_load     <= 1'b0;
            r_m_rd       <= 5'd0;
            r_w_valid    <= 1'b0;
            r_w_regwrite <= 1'b0;
            r_w_load     <= 1'b0;
            r_w_rd       <= 5'd0;
        end else if (!MemStallM) begin
            r_w_valid    <= r_m_valid;
            r_w_regwrite <= r_m_regwrite;
            r_w_load     <= r_m_load;
            r_w_rd       <= r_m_rd;
            r_m_valid    <= r_e_valid;
            r_m_regwrite <= r_e_regwrite;
            r_m_load     <= r_e_load;
            r_m_rd       <= r_e_rd;
            if (FlushE) begin
                r_e_valid    <= 1'b0;
            end else begin
                r_e_valid    <= 1'b1;
                r_e_regwrite <= RegWriteD;
                r_e_load     <= (ResultSrcD == c_src_load);
                r_e_rd       <= RdD;
                r_e_rs1      <= Rs1D;
                r_e_rs2      <= Rs2D;
            end
        end
    end

    // Counters keep running through memory freezes so freeze time is visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (StallD && (r_stall_cnt != c_cnt_max))
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            if (FlushE && (r_flush_cnt != c_cnt_max))
                r_flush_cnt <= r_flush_cnt + c_cnt_one;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_scoreboard
// Brief   : Directed-vector scoreboard bench for hazard_scoreboard (4-bit counters).
// Rev     : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int CNT_WIDTH = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [4:0]           Rs1D, Rs2D, RdD;
    logic                 RegWriteD;
    logic [1:0]           ResultSrcD;
    logic                 PCSrcE, MemStallM;
    logic                 StallF, StallD, FlushD, FlushE;
    logic [1:0]           ForwardAE, ForwardBE;
    logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt;

    typedef struct packed {
        logic [3:0]           ctrl;   // {StallF, StallD, FlushD, FlushE}
        logic [1:0]           fa;
        logic [1:0]           fb;
        logic [CNT_WIDTH-1:0] sc;
        logic [CNT_WIDTH-1:0] fc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;
    bit    done  = 1'b0;

    hazard_scoreboard #(.CNT_WIDTH(CNT_WIDTH)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD),
        .PCSrcE(PCSrcE), .MemStallM(MemStallM),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: the DUT presents a fresh response every cycle; sample mid-cycle.
    initial begin
        exp_t e, a;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = '{ctrl: {StallF, StallD, FlushD, FlushE}, fa: ForwardAE,
                       fb: ForwardBE, sc: stall_cnt, fc: flush_cnt};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL %s: got ctrl=%b fa=%b fb=%b sc=%0d fc=%0d, want ctrl=%b fa=%b fb=%b sc=%0d fc=%0d",
                             nm, a.ctrl, a.fa, a.fb, a.sc, a.fc,
                             e.ctrl, e.fa, e.fb, e.sc, e.fc);
                end
            end
        end
    end

    // One cycle of stimulus; an empty name means the cycle is not checked.
    task automatic cyc(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic [1:0] rsrc,
                       input logic pcs, input logic ms,
                       input logic [3:0] ctrl, input logic [1:0] fa, input logic [1:0] fb,
                       input int sc, input int fc, input string nm);
        exp_t e;
        rst = r; Rs1D = rs1; Rs2D = rs2; RdD = rd; RegWriteD = rw;
        ResultSrcD = rsrc; PCSrcE = pcs; MemStallM = ms;
        if (nm != "") begin
            e = '{ctrl: ctrl, fa: fa, fb: fb,
                  sc: CNT_WIDTH'(sc), fc: CNT_WIDTH'(fc)};
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        if (!done) begin
            $display("FAIL timeout: got no completion, want completion within 20000 time units");
            $fatal(1, "timeout");
        end
    end

    initial begin
        // Reset and idle state
        cyc(1, 0,0,0, 0,2'b00, 0,0, 4'b0000,2'b00,2'b00, 0,0, "");
        cyc(0, 0,0,0, 0,2'b00, 0,0, 4'b0000,2'b00,2'b00, 0,0, "reset");

        // ADD x5 then readers: forward from M, then from W
        cyc(0, 1,2,5, 1,2'b00, 0,0, 4'b0000,2'b00,2'b00, 0,0, "add_issue");
        cyc(0, 5,3,8, 1,2'b00, 0,0, 4'b0000,2'b00,2'b00, 0,0, "sub_issue");
        cyc(0, 5,0,0, 0,2'b00, 0,0, 4'b0000,2'b10,2'b00, 0,0, "fwd_m");
        cyc(0, 0,0,0, 0,2'b00, 0,0, 4'b0000,2'b01,2'b00, 0,0, "fwd_w");

        // Load-use: one stall/bubble cycle, then forward from W
        cyc(0, 1,0,6, 1,2'b01, 0,0, 4'b0000,2'b00,2'b00, 0,0, "lw_issue");
        cyc(0, 7,6,9, 1,2'b00, 0,0, 4'b1101,2'b00,2'b00, 0,0, "lw_stall");
        cyc(0, 7,6,9, 1,2'b00, 0,0, 4'b0000,2'b00,2'b00, 1,1, "bubble");
        cyc(0, 0,0,0, 0,2'b00, 0,0, 4'b0000,2'b00,2'b01, 1,1, "lw_fwd_w");

        // Load to x0 never stalls or forwards
        cyc(0, 0,0,0, 1,2'b01, 0,0, 4'b0000,2'b00,2'b00, 1,1, "ld_x0_issue");
        cyc(0, 0,0,10,1,2'b00, 0,0, 4'b0000,2'b00,2'b00, 1,1, "x0_nostall");
        cyc(0, 0,0,0, 0,2'b00, 0,0, 4'b0000,2'b00,2'b00, 1,1, "x0_nofwd");

        // Redirect squashes the LW x11 entering E, so its reader does not stall
        cyc(0, 0,0,11,1,2'b01, 1,0, 4'b0011,2'b00,2'b00, 1,1, "redirect");
        cyc(0, 11,0,12,1,2'b00,0,0, 4'b0000,2'b00,2'b00, 1,2, "post_redirect");

        // ADD x7 in M, reader in E, then a 3-cycle memory freeze
        cyc(0, 1,0,7, 1,2'b00, 0,0, 4'b0000,2'b00,2'b00, 1,2, "add7_issue");
        cyc(0, 7,0,0, 0,2'b00, 0,0, 4'b0000,2'b00,2'b00, 1,2, "rd7_issue");
        cyc(0, 0,0,0, 0,2'b00, 0,1, 4'b1100,2'b10,2'b00, 1,2, "freeze1");
        cyc(0, 0,0,0, 0,2'b00, 0,1, 4'b1100,2'b10,2'b00, 2,2, "freeze2");
        cyc(0, 0,0,0, 0,2'b00, 1,1, 4'b1100,2'b10,2'b00, 3,2, "freeze_pcs");
        cyc(0, 0,0,0, 0,2'b00, 0,0, 4'b0000,2'b10,2'b00, 4,2, "unfreeze");

        // Long freeze drives stall_cnt to saturation
        for (int i = 0; i < 11; i++)
            cyc(0, 0,0,0, 0,2'b00, 0,1, 4'b1100,2'b00,2'b00, 0,0, "");
        cyc(0, 0,0,0, 0,2'b00, 0,1, 4'b1100,2'b00,2'b00, 15,2, "sat15");
        cyc(0, 0,0,0, 0,2'b00, 0,1, 4'b1100,2'b00,2'b00, 15,2, "sat_hold");

        // Mid-run reset while a load x13 sits in decode: nothing may survive
        cyc(1, 0,0,13,1,2'b01, 0,0, 4'b0000,2'b00,2'b00, 0,0, "");
        cyc(0, 13,13,0,0,2'b00,0,0, 4'b0000,2'b00,2'b00, 0,0, "post_rst");

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
